// File: rtl/multimode_ff_bank.sv
// ============================================================================
// Module   : multimode_ff_bank
// Brief    : WIDTH-bit register bank whose bits act as D, T, SR or JK flops,
//            with clock enable, change report and SR-11 error bookkeeping.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multimode_ff_bank #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
  parameter int               CNT_W       = 8,
  parameter int               ILLEGAL_POL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] changed,
  output logic             illegal,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] c_MODE_D  = 2'b00;
  localparam logic [1:0] c_MODE_T  = 2'b01;
  localparam logic [1:0] c_MODE_SR = 2'b10;
  localparam logic [1:0] c_MODE_JK = 2'b11;

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  generate
    if (ILLEGAL_POL < 0 || ILLEGAL_POL > 2) begin : g_bad_pol
      $error("multimode_ff_bank: ILLEGAL_POL must be 0, 1 or 2");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_changed;
  logic             r_illegal;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_cnt;

  logic [WIDTH-1:0] w_q_next;
  logic             w_evt;

  // Per-bit next state; SR 11 resolves through ILLEGAL_POL so q never goes X.
  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (mode)
        c_MODE_D: w_q_next[i] = a[i];
        c_MODE_T: w_q_next[i] = r_q[i] ^ a[i];
        c_MODE_SR: begin
          unique case ({a[i], b[i]})
            2'b00: w_q_next[i] = r_q[i];
            2'b01: w_q_next[i] = 1'b0;
            2'b10: w_q_next[i] = 1'b1;
            default: begin
              if (ILLEGAL_POL == 1)      w_q_next[i] = 1'b0;
              else if (ILLEGAL_POL == 2) w_q_next[i] = 1'b1;
              else                       w_q_next[i] = r_q[i];
            end
          endcase
        end
        c_MODE_JK: begin
          unique case ({a[i], b[i]})
            2'b00:   w_q_next[i] = r_q[i];
            2'b01:   w_q_next[i] = 1'b0;
            2'b10:   w_q_next[i] = 1'b1;
            default: w_q_next[i] = ~r_q[i];
          endcase
        end
        default: w_q_next[i] = r_q[i];
      endcase
    end
  end

  // Any number of SR-11 bits in one edge is a single event.
  assign w_evt = en && (mode == c_MODE_SR) && (|(a & b));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= RESET_VAL;
      r_changed <= '0;
      r_illegal <= 1'b0;
    end else if (en) begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
      r_illegal <= w_evt;
    end else begin
      r_changed <= '0;
      r_illegal <= 1'b0;
    end
  end

  // A clear and an event on the same edge leave exactly one counted event.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
    end else if (err_clr) begin
      r_err_sticky <= w_evt;
      r_err_cnt    <= w_evt ? c_CNT_ONE : '0;
    end else if (w_evt) begin
      r_err_sticky <= 1'b1;
      if (r_err_cnt != c_CNT_MAX) r_err_cnt <= r_err_cnt + c_CNT_ONE;
    end
  end

  assign q          = r_q;
  assign q_n        = ~r_q;
  assign changed    = r_changed;
  assign illegal    = r_illegal;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;

endmodule

`default_nettype wire
